fp_exp_align_pipe: RTL

Two-stage, parametrised, valid/ready-pipelined operand alignment unit for the floating-point adder datapath. It accepts two packed floating-point operands and computes the absolute exponent difference and which operand is smaller. It then swaps the operands so the larger-exponent one is "big", and right-shifts the smaller significand by the difference, producing guard, round and sticky bits. It sits directly in front of the significand add/subtract stage and supersedes the purely combinational exponent-difference logic.

---
 rtl/fp_exp_align_pipe.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/fp_exp_align_pipe.sv
// Two-stage valid/ready operand alignment for the FP adder: exponent compare/swap,
// then right-shift of the smaller significand with guard/round/sticky capture.
module fp_exp_align_pipe #(
  parameter int EW = 4,
  parameter int MW = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EW+MW:0]   x,
  input  logic [EW+MW:0]   y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             swapped,
  output logic [EW-1:0]    exp_diff,
  output logic             big_sign,
  output logic             small_sign,
  output logic [EW-1:0]    big_exp,
  output logic [MW:0]      big_sig,
  output logic [MW:0]      small_sig,
  output logic [2:0]       grs
);

  localparam int W  = 1 + EW + MW;
  localparam int SW = MW + 1;
  localparam int XW = MW + 3;

  typedef struct packed {
    logic          swapped;
    logic [EW-1:0] diff;
    logic          big_sign;
    logic          small_sign;
    logic [EW-1:0] big_exp;
    logic [SW-1:0] big_sig;
    logic [SW-1:0] small_sig;
  } stage_t;

  logic          s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  stage_t        s1_q, s1_d, s2_q, s2_d, cand_s;
  logic [2:0]    grs_q, grs_d, grs_s;
  logic          s1_load_s, s2_load_s;
  logic [EW-1:0] exp_x_s, exp_y_s, eff_x_s, eff_y_s;
  logic [SW-1:0] sig_x_s, sig_y_s, shsig_s;
  logic [EW:0]   dxy_s, dyx_s;
  logic [XW-1:0] ext_s, shifted_s, mask_s;

  // Stage-1 candidate: effective exponents, signed difference, big/small selection
  always_comb begin
    exp_x_s = x[W-2:MW];
    exp_y_s = y[W-2:MW];
    eff_x_s = (exp_x_s != {EW{1'b0}}) ? exp_x_s : {{(EW-1){1'b0}}, 1'b1};
    eff_y_s = (exp_y_s != {EW{1'b0}}) ? exp_y_s : {{(EW-1){1'b0}}, 1'b1};
    sig_x_s = {|exp_x_s, x[MW-1:0]};
    sig_y_s = {|exp_y_s, y[MW-1:0]};
    dxy_s   = {1'b0, eff_x_s} - {1'b0, eff_y_s};
    dyx_s   = {1'b0, eff_y_s} - {1'b0, eff_x_s};
    cand_s  = '0;
    cand_s.swapped = dxy_s[EW];
    if (dxy_s[EW]) begin
      cand_s.diff       = dyx_s[EW-1:0];
      cand_s.big_sign   = y[W-1];
      cand_s.small_sign = x[W-1];
      cand_s.big_exp    = eff_y_s;
      cand_s.big_sig    = sig_y_s;
      cand_s.small_sig  = sig_x_s;
    end else begin
      cand_s.diff       = dxy_s[EW-1:0];
      cand_s.big_sign   = x[W-1];
      cand_s.small_sign = y[W-1];
      cand_s.big_exp    = eff_x_s;
      cand_s.big_sig    = sig_x_s;
      cand_s.small_sig  = sig_y_s;
    end
  end

  // Stage-2 alignment shift; beyond MW+2 positions everything collapses into sticky
  always_comb begin
    ext_s     = {s1_q.small_sig, 2'b00};
    shifted_s = ext_s >> s1_q.diff;
    for (int i = 0; i < XW; i++) begin
      mask_s[i] = (i < int'(s1_q.diff));
    end
    if (int'(s1_q.diff) < XW) begin
      shsig_s = shifted_s[XW-1:2];
      grs_s   = {shifted_s[1:0], |(ext_s & mask_s)};
    end else begin
      shsig_s = {SW{1'b0}};
      grs_s   = {2'b00, |s1_q.small_sig};
    end
  end

  // Handshake and next-state for both stages; stalled stages keep their payload
  always_comb begin
    s2_load_s  = ~s2_valid_q | out_ready;
    s1_load_s  = ~s1_valid_q | s2_load_s;
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    grs_d      = grs_q;
    if (s1_load_s) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d = cand_s;
      end else begin
        s1_d = s1_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (s2_load_s) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_d           = s1_q;
        s2_d.small_sig = shsig_s;
        grs_d          = grs_s;
      end else begin
        s2_d  = s2_q;
        grs_d = grs_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
      grs_q      <= 3'b000;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      grs_q      <= grs_d;
    end
  end

  assign in_ready   = s1_load_s;
  assign out_valid  = s2_valid_q;
  assign swapped    = s2_q.swapped;
  assign exp_diff   = s2_q.diff;
  assign big_sign   = s2_q.big_sign;
  assign small_sign = s2_q.small_sign;
  assign big_exp    = s2_q.big_exp;
  assign big_sig    = s2_q.big_sig;
  assign small_sig  = s2_q.small_sig;
  assign grs        = grs_q;

endmodule
